// File: rtl/tdm_demultiplexer_if.sv
// tdm_demultiplexer_if
// Purpose : bundles the serial lane input and the demultiplexed frame outputs
//           of the TDM demultiplexer so that both sides share one connection.
// Ports   :
//   din, din_valid, frame_start  serial lane from the transmitter
//   out0..out3                   registered slot words of the last full frame
//   addr0, addr1                 next expected slot index (LSB, MSB)
//   frame_valid                  one-cycle pulse when out0..out3 update
//   sync_err                     one-cycle pulse on a framing violation
// Modports: master drives the lane and observes the frame;
//           slave is the demultiplexer itself.
interface tdm_demultiplexer_if #(
   parameter int WIDTH = 1
);
   logic [WIDTH-1:0] din;
   logic             din_valid;
   logic             frame_start;
   logic [WIDTH-1:0] out0;
   logic [WIDTH-1:0] out1;
   logic [WIDTH-1:0] out2;
   logic [WIDTH-1:0] out3;
   logic             addr0;
   logic             addr1;
   logic             frame_valid;
   logic             sync_err;

   modport master (
      output din, din_valid, frame_start,
      input  out0, out1, out2, out3, addr0, addr1, frame_valid, sync_err
   );

   modport slave (
      input  din, din_valid, frame_start,
      output out0, out1, out2, out3, addr0, addr1, frame_valid, sync_err
   );
endinterface

// File: rtl/tdm_demultiplexer.sv
// tdm_demultiplexer
// Purpose : receive-side counterpart of a 4:1 TDM multiplexer. Words arrive on
//           one lane in slot order 0,1,2,3 with slot 0 marked by frame_start.
//           Slots are collected in shadow registers and published atomically
//           to out0..out3 once slot 3 arrives.
// Ports   :
//   clk    rising-edge system clock
//   reset  synchronous, active-high reset
//   bus    tdm_demultiplexer_if slave modport (lane in, frame out)
module tdm_demultiplexer #(
   parameter int WIDTH = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   tdm_demultiplexer_if.slave   bus
);

   typedef enum logic {
      HUNT,
      RECV
   } state_t;

   state_t           state_q;
   logic [1:0]       slotCnt_q;
   logic [WIDTH-1:0] shadow0_q;
   logic [WIDTH-1:0] shadow1_q;
   logic [WIDTH-1:0] shadow2_q;
   logic [WIDTH-1:0] out0_q;
   logic [WIDTH-1:0] out1_q;
   logic [WIDTH-1:0] out2_q;
   logic [WIDTH-1:0] out3_q;
   logic             frameValid_q;
   logic             syncErr_q;

   // Framing FSM. The slot counter doubles as the published address, so the
   // address always shows the next slot the block expects. Pulses default low
   // every cycle and are only raised for the single edge that detects an
   // event; idle (din_valid low) cycles leave all framing state untouched.
   // Slot 3 bypasses its shadow and is copied straight from din so all four
   // outputs change on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= HUNT;
         slotCnt_q    <= 2'd0;
         shadow0_q    <= '0;
         shadow1_q    <= '0;
         shadow2_q    <= '0;
         out0_q       <= '0;
         out1_q       <= '0;
         out2_q       <= '0;
         out3_q       <= '0;
         frameValid_q <= 1'b0;
         syncErr_q    <= 1'b0;
      end else begin
         frameValid_q <= 1'b0;
         syncErr_q    <= 1'b0;
         if (bus.din_valid) begin
            case (state_q)
               HUNT: begin
                  if (bus.frame_start) begin
                     shadow0_q <= bus.din;
                     slotCnt_q <= 2'd1;
                     state_q   <= RECV;
                  end else begin
                     slotCnt_q <= 2'd0;
                  end
               end
               RECV: begin
                  if (slotCnt_q == 2'd0) begin
                     if (bus.frame_start) begin
                        shadow0_q <= bus.din;
                        slotCnt_q <= 2'd1;
                     end else begin
                        syncErr_q <= 1'b1;
                        state_q   <= HUNT;
                     end
                  end else if (bus.frame_start) begin
                     syncErr_q <= 1'b1;
                     shadow0_q <= bus.din;
                     slotCnt_q <= 2'd1;
                  end else begin
                     case (slotCnt_q)
                        2'd1: begin
                           shadow1_q <= bus.din;
                           slotCnt_q <= 2'd2;
                        end
                        2'd2: begin
                           shadow2_q <= bus.din;
                           slotCnt_q <= 2'd3;
                        end
                        default: begin
                           out0_q       <= shadow0_q;
                           out1_q       <= shadow1_q;
                           out2_q       <= shadow2_q;
                           out3_q       <= bus.din;
                           frameValid_q <= 1'b1;
                           slotCnt_q    <= 2'd0;
                        end
                     endcase
                  end
               end
               default: begin
                  state_q   <= HUNT;
                  slotCnt_q <= 2'd0;
               end
            endcase
         end
      end
   end

   assign bus.out0        = out0_q;
   assign bus.out1        = out1_q;
   assign bus.out2        = out2_q;
   assign bus.out3        = out3_q;
   assign bus.addr0       = slotCnt_q[0];
   assign bus.addr1       = slotCnt_q[1];
   assign bus.frame_valid = frameValid_q;
   assign bus.sync_err    = syncErr_q;

endmodule

// File: doc/tdm_demultiplexer.md
Name: tdm_demultiplexer

Overview:
- Receive-side counterpart of the 4:1 multiplexer datapath.
- A transmitter drives words in0..in3 onto a shared lane by stepping the mux address through slots 0,1,2,3. This block takes that lane back apart, routing each slot to its own registered output.
- Slot 0 is marked by a frame_start strobe. A frame is published only after all four slots have been received.
- Frames are published atomically, with a one-cycle frame_valid pulse and sync-error detection.

Parameters:
- WIDTH, 1, bit width of each slot word (din, out0..out3).

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- din  input  WIDTH  serial lane data, one slot word per accepted cycle
- din_valid  input  1  din is valid this cycle; slot word accepted when high
- frame_start  input  1  qualifies din as slot 0; ignored when din_valid low
- out0  output  WIDTH  slot 0 word of last complete frame (registered)
- out1  output  WIDTH  slot 1 word of last complete frame (registered)
- out2  output  WIDTH  slot 2 word of last complete frame (registered)
- out3  output  WIDTH  slot 3 word of last complete frame (registered)
- addr0  output  1  LSB of next expected slot index
- addr1  output  1  MSB of next expected slot index
- frame_valid  output  1  one-cycle pulse: out0..out3 just updated with a new frame
- sync_err  output  1  one-cycle pulse: framing violation detected

Behaviour:
- Reset is synchronous, active-high, one clock, highest priority:
  - out0..out3=0, addr0=addr1=0, frame_valid=0, sync_err=0
  - shadow registers=0, state=HUNT
- Reset mid-frame discards any partial frame; outputs clear to 0.
- State is held internally as a 2-bit slot counter, with {addr1,addr0} equal to that counter.
- States:
  - HUNT: waiting for the first frame_start.
  - RECV: framed; counter is the next expected slot.
- Cycles with din_valid=0: no state change; frame_valid=0, sync_err=0.
- HUNT:
  - din_valid & frame_start: shadow0<=din, counter<=1, go to RECV.
  - din_valid & !frame_start: word dropped silently; stay in HUNT with counter=0. No sync_err, because the block has not been framed yet.
- RECV, counter=0:
  - din_valid & frame_start: shadow0<=din, counter<=1.
  - din_valid & !frame_start: sync_err pulse next cycle, word dropped, go to HUNT.
- RECV, counter=1..3:
  - din_valid & frame_start (early start): sync_err pulse next cycle, partial frame discarded, shadow0<=din, counter<=1, stay in RECV. Resynchronises on this word.
  - din_valid & !frame_start, counter 1 or 2: shadow[counter]<=din, counter<=counter+1.
  - din_valid & !frame_start, counter 3: completes the frame.
    - out0<=shadow0, out1<=shadow1, out2<=shadow2, out3<=din (all four in the same edge).
    - frame_valid=1 for exactly the next cycle; counter wraps to 0.
- Latency: out0..out3 and frame_valid change on the clock edge that accepts the slot-3 word, so they are visible the cycle after it is presented.
- out0..out3 hold their value until the next complete frame. Partial frames never reach the outputs.
- frame_valid and sync_err are registered and never high together. Neither is ever high for more than one cycle per event.
- Back-to-back frames are supported: slot 3 of frame N can be followed immediately by slot 0 of frame N+1, giving one frame per 4 accepted words.

Test Plan:
- Reset: assert reset 2 cycles mid-frame -> all outputs 0, addr=00; next frame_start restarts cleanly.
- Nominal, WIDTH=1: frame_start with din=1,0,1,1 on 4 consecutive valid cycles -> one cycle later out0..3=1,0,1,1, frame_valid high 1 cycle, addr returns to 00.
- Gaps: same frame with din_valid low for 3 cycles between slot 1 and slot 2 -> identical result; addr holds 10 during the gap; no extra pulses.
- Hunt: 3 valid words without frame_start after reset -> no sync_err, outputs stay 0. Then a full frame 0,1,1,0 -> out=0,1,1,0.
- Early start: after frame 1,1,1,1, send slot0=0, slot1=1, then frame_start with 1,0,0,1 -> sync_err pulse at the early start. Outputs hold 1,1,1,1 until the new frame completes, then become 1,0,0,1.
- Lost sync and back-to-back: 8 words with frame_start on words 1 and 5 -> 2 frame_valid pulses 4 cycles apart. Then a valid word at slot 0 without frame_start -> sync_err and a return to HUNT; outputs hold the last frame.
